tdc_frame_source: RTL
=====================

# tdc_frame_source

Coarse time-to-digital converter front end and framer for the tiny-tdc design. Synchronises the external `start`/`stop` pins and counts `clk` cycles between a `start` rising edge and the next `stop` rising edge. It then emits the result as a checksummed byte frame over the valid/ready byte interface consumed by `Uart`. It sits directly upstream of `Uart` in `top`, replacing the constant `axi_data`/`axi_valid` drive.

## Interface
Parameters:
- `COUNT_W`, 24: measurement counter width. Must be a multiple of 8 and at least 8.
- `SYNC_STAGES`, 2: flops per input synchroniser. Must be at least 2.
- `HEADER`, 8'hA5: first byte of every frame.

Ports:
- `clk`  in  1: single clock. All logic is in this domain.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: asynchronous start pin. Only rising edges matter.
- `stop`  in  1: asynchronous stop pin. Only rising edges matter.
- `axi_data`  out  8: frame byte.
- `axi_valid`  out  1: `axi_data` holds a valid byte.
- `axi_ready`  in  1: sink accepts the byte this cycle.
- `busy`  out  1: high while in MEASURE or SEND.

## Operation
- Each of `start` and `stop` passes through a `SYNC_STAGES` synchroniser, then a rising-edge detector.
  - Synchroniser flops and the previous-value flop reset to 1.
  - A pin already high at reset release therefore produces no edge.
- State machine states:
  - IDLE: waiting for a start edge.
  - MEASURE: counting cycles until a stop edge.
  - SEND: emitting the frame.
- IDLE:
  - On `start_edge`: clear `cnt` to 0, clear `ovf`, go to MEASURE.
  - A `stop_edge` in the same cycle is ignored.
  - A `stop_edge` alone is ignored.
- MEASURE, every cycle:
  - Compute `nxt = cnt + 1`, saturating at all-ones. Set `ovf` if `cnt` is already all-ones.
  - If `stop_edge`: latch `nxt` and `ovf` into the result register, set byte index to 0, go to SEND.
  - Else: `cnt <= nxt`.
  - Further `start_edge`s are ignored.
  - There is no timeout: without a stop edge, the block stays in MEASURE with `cnt` saturated.
- Measured value: start edge detected at cycle t, stop edge detected at cycle t+k gives result k (minimum 1). Equal synchroniser latency on both pins cancels.
- Frame is N = COUNT_W/8 + 3 bytes, in this order:
  - `HEADER`.
  - Status byte: bit0 = `ovf`, bits 7:1 = 0.
  - Result bytes, MSB first.
  - Checksum = XOR of the status byte and all result bytes. `HEADER` is excluded.
- SEND:
  - `axi_valid` is high and `axi_data` = frame[idx].
  - On `axi_valid && axi_ready`: if `idx` == N-1, go to IDLE; else `idx <= idx + 1`.
  - All start/stop edges during SEND are dropped. No queueing.

## Timing
- Reset values: `axi_valid` 0, `axi_data` 0, `busy` 0, state IDLE, `cnt`, result and `ovf` all 0.
- Pin to edge pulse: `SYNC_STAGES` + 1 cycles.
- `axi_valid` rises the cycle after the `stop_edge` cycle.
- `axi_valid` and `axi_data` are registered. Neither depends combinationally on `axi_ready`.
- While `axi_valid` is high and `axi_ready` is low, `axi_data` is stable and `axi_valid` stays high.
- With `axi_ready` held high, one byte transfers per cycle. `axi_valid` drops the cycle after the last handshake.
- The earliest new start edge is accepted in the first IDLE cycle after the frame completes.
- `busy` is high from the cycle after `start_edge` until the cycle after the final handshake.
- Reset asserted mid-MEASURE or mid-SEND: all outputs clear immediately and the frame is abandoned. The next frame begins with `HEADER`.

## Structure
- Package `tdc_pkg` holds:
  - `state_t` enum {IDLE, MEASURE, SEND}.
  - `STATUS_OVF_BIT` = 0.
  - A `frame_len(COUNT_W)` function returning COUNT_W/8 + 3.
- Sub-module `sync_edge` (parameter `STAGES`; ports `clk`, `rst`, `din`, `rise`), instantiated twice: synchroniser chain plus rising-edge pulse.
- In `top`, `tdc_frame_source` drives `Uart` through `axi_data`, `axi_valid` and `axi_ready`.

## Test plan
- Basic frame: COUNT_W=24, `axi_ready`=1, start pulse, stop pulse 100 cycles later → bytes A5, 00, 00, 00, 64, 64, consecutive cycles.
- Overflow: COUNT_W=8, stop 300 cycles after start → A5, 01, FF, FE.
- Minimum interval: stop edge detected 1 cycle after start edge → A5, 00, 00, 00, 01, 01.
- Backpressure: random `axi_ready`, including 20-cycle low stretches → `axi_data` stable while stalled; exactly 6 bytes, none lost or repeated.
- Edge rules:
  - start and stop rising together in IDLE, stop 5 cycles later → count 5.
  - stop alone in IDLE → no frame.
  - extra start in MEASURE → count still measured from the first start.
  - start/stop during SEND → no second frame.
- Reset: reset during SEND at byte 2 → `axi_valid` is 0 in the same cycle. A following measurement of 10 emits A5, 00, 00, 00, 0A, 0A.

Source files
------------

// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared types and helpers for the TDC front end and framer.
//               state_t    - framer state machine encoding
//               STATUS_OVF_BIT - bit position of the overflow flag in the
//                            status byte
//               frame_len  - total frame length in bytes for a given
//                            counter width (header + status + result + csum)
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    localparam int STATUS_OVF_BIT = 0;

    function automatic int frame_len(input int count_w);
        return count_w / 8 + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_frame_source_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchroniser for an asynchronous pin followed by a
//               registered rising-edge detector. All flops reset to 1 so a
//               pin that is already high when reset releases never produces
//               an edge. Pin-to-pulse latency is STAGES + 1 cycles.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               din  - asynchronous input pin
//               rise - one-cycle pulse per synchronised rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/tdc_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : tdc_frame_source
// Description : Coarse TDC: counts clk cycles between a start rising edge and
//               the next stop rising edge, then emits
//               HEADER, status, result (MSB first), checksum
//               over a valid/ready byte interface. Checksum is the XOR of the
//               status and result bytes.
// Ports       : clk       - clock
//               rst       - asynchronous active-high reset
//               start     - asynchronous start pin (rising edge)
//               stop      - asynchronous stop pin (rising edge)
//               axi_data  - frame byte (registered)
//               axi_valid - axi_data valid (registered)
//               axi_ready - sink accepts byte
//               busy      - high while measuring or sending
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_frame_source
    import tdc_pkg::*;
#(
    parameter int         COUNT_W     = 24,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] axi_data,
    output logic       axi_valid,
    input  logic       axi_ready,
    output logic       busy
);

    localparam int c_FRAME_LEN = frame_len(COUNT_W);
    localparam int c_RES_BYTES = COUNT_W / 8;
    localparam int c_IDX_W     = $clog2(c_FRAME_LEN);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [COUNT_W-1:0]   r_cnt;
    logic                 r_ovf;
    logic [COUNT_W-1:0]   r_result;
    logic                 r_res_ovf;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_axi_valid;
    logic [7:0]           r_axi_data;

    logic                 w_start_edge;
    logic                 w_stop_edge;
    logic [COUNT_W-1:0]   w_nxt;
    logic                 w_ovf_nxt;
    logic                 w_hs;
    logic                 w_last;
    logic [c_IDX_W-1:0]   w_idx_inc;
    logic [7:0]           w_status;
    logic [7:0]           w_chk;
    logic [7:0]           w_next_byte;
    logic                 w_valid_nxt;
    logic [7:0]           w_data_nxt;

    sync_edge #(.STAGES(SYNC_STAGES)) u_start_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (start),
        .rise (w_start_edge)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_stop_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (stop),
        .rise (w_stop_edge)
    );

    // Saturating increment; overflow is sticky once the counter has been
    // all-ones for a cycle.
    assign w_nxt     = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_ovf_nxt = r_ovf | (&r_cnt);

    assign w_hs      = r_axi_valid & axi_ready;
    assign w_last    = (r_idx == c_IDX_W'(c_FRAME_LEN - 1));
    assign w_idx_inc = r_idx + 1'b1;

    // Byte that follows the one currently presented. The header is never a
    // "next" byte because it is loaded directly on entry to SEND.
    always_comb begin
        w_status                 = '0;
        w_status[STATUS_OVF_BIT] = r_res_ovf;
        w_chk                    = w_status;
        for (int b = 0; b < c_RES_BYTES; b++) begin
            w_chk = w_chk ^ r_result[8*b +: 8];
        end
        w_next_byte = '0;
        if (w_idx_inc == c_IDX_W'(1)) begin
            w_next_byte = w_status;
        end else if (w_idx_inc == c_IDX_W'(c_FRAME_LEN - 1)) begin
            w_next_byte = w_chk;
        end else begin
            for (int b = 0; b < c_RES_BYTES; b++) begin
                if (w_idx_inc == c_IDX_W'(2 + b)) begin
                    w_next_byte = r_result[COUNT_W-1-8*b -: 8];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_edge)    w_state_nxt = MEASURE;
            MEASURE: if (w_stop_edge)     w_state_nxt = SEND;
            SEND:    if (w_hs && w_last)  w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered byte interface
    always_comb begin
        w_valid_nxt = 1'b0;
        w_data_nxt  = '0;
        case (r_state)
            MEASURE: begin
                if (w_stop_edge) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = HEADER;
                end
            end
            SEND: begin
                w_valid_nxt = r_axi_valid;
                w_data_nxt  = r_axi_data;
                if (w_hs) begin
                    w_valid_nxt = !w_last;
                    w_data_nxt  = w_last ? 8'h00 : w_next_byte;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_data_nxt  = '0;
            end
        endcase
    end

    // Measurement and frame datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_result    <= '0;
            r_res_ovf   <= 1'b0;
            r_idx       <= '0;
            r_axi_valid <= 1'b0;
            r_axi_data  <= '0;
        end else begin
            r_axi_valid <= w_valid_nxt;
            r_axi_data  <= w_data_nxt;
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_stop_edge) begin
                        r_result  <= w_nxt;
                        r_res_ovf <= w_ovf_nxt;
                        r_idx     <= '0;
                    end else begin
                        r_cnt <= w_nxt;
                        r_ovf <= w_ovf_nxt;
                    end
                end
                SEND: begin
                    if (w_hs && !w_last) begin
                        r_idx <= w_idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign axi_valid = r_axi_valid;
    assign axi_data  = r_axi_data;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
